// File: rtl/afe_spi_pkg.sv
// Shared definitions for the AFE SPI initiator: FSM encoding, default
// frame/timing constants and the SPI mode agreed with the AFE firmware.
package afe_spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } afe_spi_state_e;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefClkDiv   = 2;
  localparam int unsigned DefCsSetup  = 2;
  localparam int unsigned DefCsHold   = 2;
  localparam logic        DefIdleMosi = 1'b1;

  // CPOL=0, CPHA=0; mirrors the mode field in the AFE firmware register map.
  localparam logic [1:0]  SpiMode     = 2'b00;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/afe_spi_tick.sv
// Half-period timer: one-cycle tick every ClkDiv enabled cycles, restartable.
module afe_spi_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the last count of each half-period while enabled.
  always_comb begin
    tick_o = en_i && (cnt_q == CntLast);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/afe_spi_master.sv
// SPI mode-0 initiator for the AFE CPLD slave port: one full-duplex
// DATA_W-bit frame per accepted start, MSB first, all outputs registered.
module afe_spi_master
  import afe_spi_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned CS_SETUP  = DefCsSetup,
  parameter int unsigned CS_HOLD   = DefCsHold,
  parameter logic        IDLE_MOSI = DefIdleMosi
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              cs_b_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam int unsigned ShW  = $clog2(max_u(CS_SETUP, CS_HOLD) + 1);
  localparam int unsigned BitW = $clog2(DATA_W + 1);

  localparam logic [ShW-1:0]  SetupLast = ShW'(CS_SETUP - 1);
  localparam logic [ShW-1:0]  HoldLast  = ShW'(CS_HOLD - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(DATA_W - 1);

  afe_spi_state_e    state_q, state_d;
  logic [ShW-1:0]    sh_cnt_q, sh_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cs_b_q, cs_b_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              miso_q;
  logic              tick;
  logic              tick_clr;

  afe_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (tick_clr),
    .en_i   (state_q == StShift),
    .tick_o (tick)
  );

  // Frame sequencing: next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    cs_b_d    = cs_b_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tick_clr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StSetup;
          tx_sr_d   = tx_data_i;
          mosi_d    = tx_data_i[DATA_W-1];
          cs_b_d    = 1'b0;
          busy_d    = 1'b1;
          sh_cnt_d  = '0;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
        end
      end
      StSetup: begin
        if (sh_cnt_q == SetupLast) begin
          state_d  = StShift;
          tick_clr = 1'b1;
        end else begin
          sh_cnt_d = sh_cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (tick) begin
          if (!sclk_q) begin
            // Rising edge: sample the registered MISO.
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_q};
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BitLast) begin
              // Last falling edge: MOSI keeps the final bit through hold.
              state_d  = StHold;
              sh_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
              mosi_d    = tx_sr_q[DATA_W-2];
            end
          end
        end
      end
      StHold: begin
        if (sh_cnt_q == HoldLast) begin
          state_d   = StIdle;
          cs_b_d    = 1'b1;
          mosi_d    = IDLE_MOSI;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end else begin
          sh_cnt_d = sh_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      sh_cnt_q  <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      cs_b_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= IDLE_MOSI;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      cs_b_q    <= cs_b_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      miso_q    <= miso_i;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign cs_b_o    = cs_b_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Bench for afe_spi_master: AFE slave model, directed vector table,
// multi-cycle corner sequences and randomized frames.
module tb_afe_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, start6;
  logic [7:0] tx_data, tx6;
  logic       busy, done, cs_b, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic       busy6, done6, cs_b6, sclk6, mosi6;
  logic [7:0] rx6;

  afe_spi_master #(
    .DATA_W(8), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .IDLE_MOSI(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .tx_data_i(tx_data),
    .busy_o(busy), .done_o(done), .rx_data_o(rx_data), .cs_b_o(cs_b),
    .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso)
  );

  afe_spi_master #(
    .DATA_W(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .IDLE_MOSI(1'b1)
  ) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start6), .tx_data_i(tx6),
    .busy_o(busy6), .done_o(done6), .rx_data_o(rx6), .cs_b_o(cs_b6),
    .sclk_o(sclk6), .mosi_o(mosi6), .miso_i(1'b1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // AFE slave model: loads its reply on CS_B fall, samples MOSI on SCLK rise,
  // presents the next reply bit after SCLK fall.
  logic [7:0] slave_data = 8'h00;
  logic [7:0] s_sr = 8'h00;
  logic [7:0] cap = 8'h00;
  logic       s_miso = 1'b0;
  logic       loopback = 1'b0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  int         rises = 0;
  int         idle_bad = 0;

  assign miso = loopback ? mosi : s_miso;

  always @(negedge clk) begin
    prev_cs   <= cs_b;
    prev_sclk <= sclk;
    if (prev_cs && !cs_b) begin
      s_sr   <= slave_data;
      s_miso <= slave_data[7];
      rises  <= 0;
      cap    <= 8'h00;
    end else begin
      if (!prev_sclk && sclk) begin
        cap   <= {cap[6:0], mosi};
        rises <= rises + 1;
      end
      if (prev_sclk && !sclk) begin
        s_sr   <= {s_sr[6:0], 1'b0};
        s_miso <= s_sr[6];
      end
    end
    if (cs_b && (mosi !== 1'b1 || sclk !== 1'b0)) idle_bad <= idle_bad + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bounded wait for DONE of dut (which=0) or dut6 (which=1).
  task automatic wait_done(input int which, output int d, output bit ok);
    ok = 1'b0;
    d  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 0 && done === 1'b1) || (which == 1 && done6 === 1'b1)) begin
        d  = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] sd, input logic lp,
                           input logic [7:0] exp_rx);
    int c, d;
    bit ok;
    @(negedge clk);
    tx_data    = tx;
    slave_data = sd;
    loopback   = lp;
    start      = 1'b1;
    c          = cyc;
    @(negedge clk);
    start   = 1'b0;
    tx_data = 8'($urandom);
    chk("accept_busy", busy, 1);
    chk("accept_csb", cs_b, 0);
    wait_done(0, d, ok);
    if (ok) begin
      chk("latency", d - (c + 1), 36);
      chk("rx_data", rx_data, exp_rx);
      chk("mosi_bits", cap, tx);
      chk("sclk_rises", rises, 8);
      chk("busy_at_done", busy, 0);
      @(negedge clk);
      chk("done_width", done, 0);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sd;
    logic       lp;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #400000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c, d, d2, ndone;
    bit ok;
    logic [7:0] rxs, rtx, rsd;
    logic rlp;

    vecs[0] = '{tx: 8'h69, sd: 8'h00, lp: 1'b1, exp_rx: 8'h69};
    vecs[1] = '{tx: 8'hA5, sd: 8'h3C, lp: 1'b0, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h00, sd: 8'hFF, lp: 1'b0, exp_rx: 8'hFF};
    vecs[3] = '{tx: 8'hFF, sd: 8'h00, lp: 1'b0, exp_rx: 8'h00};

    rst_n = 1'b0; start = 1'b0; start6 = 1'b0; tx_data = 8'h00; tx6 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_csb", cs_b, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_csb6", cs_b6, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 4; i++) run_frame(vecs[i].tx, vecs[i].sd, vecs[i].lp, vecs[i].exp_rx);

    // START pulses mid-frame are ignored.
    @(negedge clk);
    tx_data = 8'h5A; slave_data = 8'hC3; loopback = 1'b0; start = 1'b1; c = cyc;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; d = 0; rxs = 8'h00;
    for (int i = 1; i <= 60; i++) begin
      start = (i == 5 || i == 20);
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        d   = cyc;
        rxs = rx_data;
      end
    end
    start = 1'b0;
    chk("ignore_done_count", ndone, 1);
    chk("ignore_latency", d - (c + 1), 36);
    chk("ignore_rx", rxs, 8'hC3);
    chk("ignore_rx_after", rx_data, 8'hC3);
    chk("ignore_idle_csb", cs_b, 1);
    chk("ignore_idle_busy", busy, 0);

    // START held across DONE: back-to-back frames, TX changed after accept.
    @(negedge clk);
    loopback = 1'b1; tx_data = 8'h01; start = 1'b1; c = cyc;
    @(negedge clk);
    tx_data = 8'hFE;
    chk("b2b_busy", busy, 1);
    wait_done(0, d, ok);
    if (ok) begin
      chk("b2b_latency1", d - (c + 1), 36);
      chk("b2b_rx1", rx_data, 8'h01);
      chk("b2b_csb_high", cs_b, 1);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_csb_gap", cs_b, 0);
      chk("b2b_busy2", busy, 1);
      wait_done(0, d2, ok);
      if (ok) begin
        chk("b2b_latency2", d2 - (d + 1), 36);
        chk("b2b_rx2", rx_data, 8'hFE);
        chk("b2b_mosi2", cap, 8'hFE);
      end
    end
    start = 1'b0;
    loopback = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-SHIFT.
    tx_data = 8'h33; slave_data = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_csb", cs_b, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_csb", cs_b, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rx", rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_frame(8'h96, 8'h4B, 1'b0, 8'h4B);

    // Fastest timing, MISO tied high.
    @(negedge clk);
    tx6 = 8'h5A; start6 = 1'b1; c = cyc;
    @(negedge clk);
    start6 = 1'b0;
    chk("fast_busy", busy6, 1);
    wait_done(1, d, ok);
    if (ok) begin
      chk("fast_latency", d - (c + 1), 18);
      chk("fast_rx", rx6, 8'hFF);
      @(negedge clk);
      chk("fast_done_width", done6, 0);
    end

    // Randomized frames against the slave model.
    for (int i = 0; i < 10; i++) begin
      rtx = 8'($urandom);
      rsd = 8'($urandom);
      rlp = 1'($urandom_range(0, 1));
      run_frame(rtx, rsd, rlp, rlp ? rtx : rsd);
    end

    repeat (3) @(negedge clk);
    chk("idle_levels", idle_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
